pool_avg_window_feeder: RTL and testbench

- Initiator side of the average-pool unit interface: fetches one pool window (pool_size x pool_size FP16 elements per lane, PARA_POOL_Y lanes) from feature-map memory and streams it into PARA_POOL_Y AvgPoolUnitFloat16 instances, one element per cycle.
- Sequences their active-low unit reset, waits until every unit reports result_ready, captures the lane results and hands them downstream over a valid/ready port.
- Sits between the feature-map buffer and the pool unit array inside the pooling layer.

---
 rtl/pool_avg_window_feeder_pkg.sv | 15 +
 rtl/pool_window_addr_gen.sv | 51 +++++
 rtl/pool_avg_window_feeder.sv | 105 ++++++++++
 tb/tb_pool_avg_window_feeder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/pool_avg_window_feeder_pkg.sv
// Shared CNN pooling parameters and the window feeder state encoding.
package pool_avg_window_feeder_pkg;
    localparam int PARA_POOL_Y     = 3;
    localparam int DATA_WIDTH      = 16;
    localparam int POOL_SIZE_WIDTH = 3;
    localparam int ADDR_WIDTH      = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT_RES,
        ST_OUT,
        ST_CLR
    } feed_state_e;
endpackage

// File: rtl/pool_window_addr_gen.sv
// Row-major window address walker: row-start accumulator plus column counter.
module pool_window_addr_gen #(
    parameter int PSW = 3,
    parameter int AW  = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          step,
    input  logic [PSW-1:0] pool_size,
    input  logic [AW-1:0]  base_addr,
    input  logic [AW-1:0]  row_stride,
    output logic [AW-1:0]  next_addr,
    output logic           last
);
    logic [AW-1:0]  row_start;
    logic [AW-1:0]  stride_q;
    logic [PSW-1:0] ps_q;
    logic [PSW-1:0] col;
    logic [PSW-1:0] row;
    logic           col_end;

    // Tracks the position of the read being issued this cycle; next_addr is its successor.
    assign col_end   = (col == ps_q - PSW'(1));
    assign last      = col_end && (row == ps_q - PSW'(1));
    assign next_addr = col_end ? (row_start + stride_q) : (row_start + AW'(col) + AW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_start <= '0;
            stride_q  <= '0;
            ps_q      <= '0;
            col       <= '0;
            row       <= '0;
        end else if (load) begin
            row_start <= base_addr;
            stride_q  <= row_stride;
            ps_q      <= pool_size;
            col       <= '0;
            row       <= '0;
        end else if (step) begin
            if (col_end) begin
                col       <= '0;
                row       <= row + PSW'(1);
                row_start <= row_start + stride_q;
            end else begin
                col <= col + PSW'(1);
            end
        end
    end
endmodule

// File: rtl/pool_avg_window_feeder.sv
// Fetches one pool window, streams it into the average-pool units and forwards their results.
module pool_avg_window_feeder
    import pool_avg_window_feeder_pkg::*;
#(
    parameter int PARA_POOL_Y_P = PARA_POOL_Y,
    parameter int DW            = DATA_WIDTH,
    parameter int PSW           = POOL_SIZE_WIDTH,
    parameter int AW            = ADDR_WIDTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [PSW-1:0]              pool_size,
    input  logic [AW-1:0]               base_addr,
    input  logic [AW-1:0]               row_stride,
    output logic                        busy,
    output logic                        rd_en,
    output logic [AW-1:0]               rd_addr,
    input  logic [PARA_POOL_Y_P*DW-1:0] rd_data,
    output logic                        mpu_rst,
    output logic [PARA_POOL_Y_P*DW-1:0] avg_input_data,
    output logic [2*PSW-1:0]            data_num,
    input  logic [PARA_POOL_Y_P-1:0]    mpu_out_ready,
    input  logic [PARA_POOL_Y_P*DW-1:0] mpu_result,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [PARA_POOL_Y_P*DW-1:0] res_data
);
    feed_state_e    state;
    logic           start_ok;
    logic [AW-1:0]  next_addr;
    logic           last;
    logic [2*PSW-1:0] ps_ext;

    assign start_ok       = (state == ST_IDLE) && start && (pool_size != '0);
    assign ps_ext         = (2*PSW)'(pool_size);
    assign avg_input_data = rd_data;

    pool_window_addr_gen #(.PSW(PSW), .AW(AW)) u_addr_gen (
        .clk        (clk),
        .rst        (rst),
        .load       (start_ok),
        .step       (state == ST_FEED),
        .pool_size  (pool_size),
        .base_addr  (base_addr),
        .row_stride (row_stride),
        .next_addr  (next_addr),
        .last       (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            mpu_rst   <= 1'b0;
            data_num  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    mpu_rst <= 1'b0;
                    if (start_ok) begin
                        busy     <= 1'b1;
                        rd_en    <= 1'b1;
                        rd_addr  <= base_addr;
                        data_num <= ps_ext * ps_ext;
                        state    <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    // Release lands on the cycle the first read data is valid.
                    mpu_rst <= 1'b1;
                    if (last) begin
                        rd_en <= 1'b0;
                        state <= ST_WAIT_RES;
                    end else begin
                        rd_addr <= next_addr;
                    end
                end
                ST_WAIT_RES: begin
                    if (&mpu_out_ready) begin
                        res_data  <= mpu_result;
                        res_valid <= 1'b1;
                        state     <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        mpu_rst   <= 1'b0;
                        state     <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pool_avg_window_feeder.sv
// Directed bench: models feature-map memory and the pool units, checks addressing, streaming and handshake.
module tb_pool_avg_window_feeder;
    localparam int NL = 3;
    localparam int DW = 16;
    localparam int PSW = 3;
    localparam int AW = 10;

    logic clk, rst, start, busy, rd_en, mpu_rst, res_valid, res_ready;
    logic [PSW-1:0]   pool_size;
    logic [AW-1:0]    base_addr, row_stride, rd_addr;
    logic [NL*DW-1:0] rd_data, avg_input_data, mpu_result, res_data;
    logic [2*PSW-1:0] data_num;
    logic [NL-1:0]    mpu_out_ready;

    int checks = 0;
    int failures = 0;

    logic [NL*DW-1:0] mem [0:(1<<AW)-1];
    logic [AW-1:0]    addr_q [$];
    logic [NL*DW-1:0] beat_q [$];
    int               u_n = 0;
    int               u_dly [NL];
    logic [NL*DW-1:0] u_res = '0;
    int               u_cnt = 0;

    typedef struct {
        int               ps;
        int               base;
        int               stride;
        logic [NL*DW-1:0] fill;   // 0 selects the irregular 2x2 pattern
        logic [NL*DW-1:0] exp_res;
        int               d0, d1, d2;
        int               hold;
    } vec_t;
    vec_t vecs [6];

    pool_avg_window_feeder dut (
        .clk(clk), .rst(rst), .start(start), .pool_size(pool_size),
        .base_addr(base_addr), .row_stride(row_stride), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .mpu_rst(mpu_rst),
        .avg_input_data(avg_input_data), .data_num(data_num),
        .mpu_out_ready(mpu_out_ready), .mpu_result(mpu_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
            addr_q.push_back(rd_addr);
        end
    end

    // Pool unit stand-in: counts un-reset beats, lane i ready dly[i] cycles after the Nth beat.
    always @(posedge clk) begin
        if (!mpu_rst) u_cnt <= 0;
        else begin
            if (u_cnt < u_n) beat_q.push_back(avg_input_data);
            u_cnt <= u_cnt + 1;
        end
    end

    always_comb begin
        mpu_out_ready = '0;
        mpu_result    = '0;
        for (int i = 0; i < NL; i++) begin
            mpu_out_ready[i] = mpu_rst && (u_cnt >= u_n + u_dly[i]);
            mpu_result[DW*i +: DW] = mpu_out_ready[i] ? u_res[DW*i +: DW] : 16'hdead;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic fill_window(input vec_t v);
        if (v.fill == '0) begin
            mem[5]  = 48'h3c00_4000_3c00;
            mem[6]  = 48'h4200_4400_3c00;
            mem[13] = 48'h3c00_4400_3c00;
            mem[14] = 48'h4200_4000_3c00;
        end else begin
            for (int r = 0; r < v.ps; r++)
                for (int c = 0; c < v.ps; c++)
                    mem[(v.base + r*v.stride + c) % (1<<AW)] = v.fill;
        end
    endtask

    task automatic run_win(input vec_t v);
        int n;
        int to;
        int ea;
        logic drop, unstable;
        n = v.ps * v.ps;
        u_n = n; u_dly[0] = v.d0; u_dly[1] = v.d1; u_dly[2] = v.d2; u_res = v.exp_res;
        addr_q.delete(); beat_q.delete();
        @(negedge clk);
        start = 1'b1; pool_size = PSW'(v.ps); base_addr = AW'(v.base); row_stride = AW'(v.stride);
        @(negedge clk);
        start = 1'b0;
        chk("feed_rd_en", 64'(rd_en), 64'(1));
        chk("feed_first_addr", 64'(rd_addr), 64'(v.base % (1<<AW)));
        chk("mpu_rst_low_first_read", 64'(mpu_rst), 64'(0));
        chk("busy_in_feed", 64'(busy), 64'(1));
        @(negedge clk);
        chk("mpu_rst_rise", 64'(mpu_rst), 64'(1));
        to = 0; drop = 1'b0;
        while (!res_valid && to < 300) begin
            @(negedge clk);
            to++;
            if (!mpu_rst) drop = 1'b1;
        end
        chk("res_valid_timeout", 64'(res_valid), 64'(1));
        if (!res_valid) return;
        chk("mpu_rst_held", 64'(drop), 64'(0));
        chk("data_num", 64'(data_num), 64'(n));
        chk("res_data", 64'(res_data), 64'(v.exp_res));
        chk("read_count", 64'(addr_q.size()), 64'(n));
        chk("beat_count", 64'(beat_q.size()), 64'(n));
        for (int r = 0; r < v.ps; r++)
            for (int c = 0; c < v.ps; c++) begin
                ea = (v.base + r*v.stride + c) % (1<<AW);
                if (r*v.ps + c < addr_q.size())
                    chk("rd_addr_seq", 64'(addr_q[r*v.ps + c]), 64'(ea));
                if (r*v.ps + c < beat_q.size())
                    chk("unit_beat", 64'(beat_q[r*v.ps + c]), 64'(mem[ea]));
            end
        unstable = 1'b0;
        for (int h = 0; h < v.hold; h++) begin
            start = (h == 3); pool_size = 3'd2;
            @(negedge clk);
            if (!res_valid || res_data !== v.exp_res || rd_en || !busy) unstable = 1'b1;
        end
        if (v.hold > 0) begin
            chk("backpressure_stable", 64'(unstable), 64'(0));
            chk("data_num_after_hold", 64'(data_num), 64'(n));
        end
        res_ready = 1'b1; start = 1'b1;
        @(negedge clk);
        res_ready = 1'b0; start = 1'b0;
        chk("clr_res_valid", 64'(res_valid), 64'(0));
        chk("clr_mpu_rst", 64'(mpu_rst), 64'(0));
        chk("clr_busy", 64'(busy), 64'(1));
        chk("clr_no_read", 64'(rd_en), 64'(0));
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_mpu_rst", 64'(mpu_rst), 64'(0));
        chk("idle_no_read", 64'(rd_en), 64'(0));
    endtask

    initial begin
        vecs[0] = '{3, 0,    3, 48'h3c00_4000_4200, 48'h3c00_4000_4200, 0, 0, 0, 0};
        vecs[1] = '{2, 5,    8, 48'h0,              48'h4000_4200_3c00, 0, 0, 0, 0};
        vecs[2] = '{3, 0,    3, 48'h3c00_4000_4200, 48'h3c00_4000_4200, 0, 0, 0, 10};
        vecs[3] = '{2, 1023, 4, 48'h4400_3c00_4000, 48'h4400_3c00_4000, 3, 0, 6, 0};
        vecs[4] = '{1, 7,    0, 48'h4200_4200_4200, 48'h4200_4200_4200, 0, 2, 1, 2};
        vecs[5] = '{7, 100,  9, 48'h3c00_3c00_3c00, 48'h3c00_3c00_3c00, 1, 1, 1, 0};
        for (int a = 0; a < (1<<AW); a++) mem[a] = '0;
        for (int i = 0; i < NL; i++) u_dly[i] = 0;
        rst = 1'b0; start = 1'b0; res_ready = 1'b0;
        pool_size = '0; base_addr = '0; row_stride = '0;
        #1;
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_rd_en", 64'(rd_en), 64'(0));
        chk("rst_rd_addr", 64'(rd_addr), 64'(0));
        chk("rst_mpu_rst", 64'(mpu_rst), 64'(0));
        chk("rst_data_num", 64'(data_num), 64'(0));
        chk("rst_res_valid", 64'(res_valid), 64'(0));
        chk("rst_res_data", 64'(res_data), 64'(0));
        #11 rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            fill_window(vecs[i]);
            run_win(vecs[i]);
        end

        // pool_size of zero is not a request
        @(negedge clk);
        start = 1'b1; pool_size = 3'd0;
        @(negedge clk);
        start = 1'b0;
        chk("ps0_busy", 64'(busy), 64'(0));
        chk("ps0_rd_en", 64'(rd_en), 64'(0));
        repeat (2) @(negedge clk);
        chk("ps0_mpu_rst", 64'(mpu_rst), 64'(0));
        chk("ps0_busy_later", 64'(busy), 64'(0));

        // async reset while the fourth read of a 3x3 window is on the bus
        fill_window(vecs[0]);
        u_n = 9; u_res = vecs[0].exp_res;
        for (int i = 0; i < NL; i++) u_dly[i] = 0;
        @(negedge clk);
        start = 1'b1; pool_size = 3'd3; base_addr = '0; row_stride = 10'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_feed_addr", 64'(rd_addr), 64'(3));
        #2 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'(0));
        chk("mid_rst_rd_en", 64'(rd_en), 64'(0));
        chk("mid_rst_rd_addr", 64'(rd_addr), 64'(0));
        chk("mid_rst_mpu_rst", 64'(mpu_rst), 64'(0));
        chk("mid_rst_data_num", 64'(data_num), 64'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        fill_window(vecs[1]);
        run_win(vecs[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
